// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the ring-list FIFO and its UART transmitter.
// master: the consumer issuing read requests; slave: the FIFO answering them.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_val;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_val
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_val
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO one word at a time and serializes each word as a UART frame:
// start bit, DATA_WIDTH data bits LSB first, stop bit. Outputs are registered
// from the next-state values so they line up with the state register.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  fifo_uart_tx_if.master  fif,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [BAUD_W-1:0]     baud_r, baud_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  tx_r, tx_s;
  logic                  busy_r, busy_s;
  logic                  rd_en_r, rd_en_s;
  logic                  frame_done_r, frame_done_s;
  logic                  baud_end_s;

  assign tx             = tx_r;
  assign busy           = busy_r;
  assign frame_done     = frame_done_r;
  assign fif.fifo_rd_en = rd_en_r;

  // Next-state, counter/shift updates, and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    baud_end_s = (baud_r == BAUD_LAST);

    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        state_s = RESP;
      end
      RESP: begin
        // The response is consumed even if en dropped meanwhile, so no word is lost.
        if (fif.fifo_rd_val) begin
          shift_s = fif.fifo_rd_data;
          baud_s  = BAUD_W'(0);
          bit_s   = BIT_W'(0);
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_s  = BAUD_W'(0);
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s  = BAUD_W'(0);
          shift_s = shift_r >> 1;
          if (bit_r == BIT_LAST) begin
            bit_s   = BIT_W'(0);
            state_s = STOP;
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_s = BAUD_W'(0);
          if (en) begin
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = BAUD_W'(0);
        bit_s   = BIT_W'(0);
      end
    endcase

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase

    busy_s       = (state_s != IDLE);
    rd_en_s      = (state_s == REQ);
    frame_done_s = (state_s == STOP) && (baud_s == BAUD_LAST);
  end

  // State, counters, shift register and registered outputs; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      baud_r       <= BAUD_W'(0);
      bit_r        <= BIT_W'(0);
      shift_r      <= {DATA_WIDTH{1'b0}};
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      rd_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      tx_r         <= tx_s;
      busy_r       <= busy_s;
      rd_en_r      <= rd_en_s;
      frame_done_r <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and a UART
// receiver model decodes tx frame by frame against the words actually read.
module tb_fifo_uart_tx;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic tx, busy, frame_done;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) fif ();

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .en(en), .fif(fif),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] sent_q[$];
  int gap_q[$];
  int pulse_q[$];
  int cycle = 0, frames = 0, rd_pulses = 0;
  int last_pulse = -100, last_end = -100, start_after_pulse = 0;
  int pos = 0, fd_bad = 0, fd_stray = 0;
  bit in_frame = 1'b0;
  logic samples [FRAME];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: every read request gets a response in the following cycle.
  always @(posedge clk) begin
    if (reset) begin
      fif.fifo_rd_val <= 1'b0;
    end else if (fif.fifo_rd_en) begin
      if (src_q.size() > 0) begin
        fif.fifo_rd_data <= src_q[0];
        fif.fifo_rd_val  <= 1'b1;
        sent_q.push_back(src_q[0]);
        void'(src_q.pop_front());
      end else begin
        fif.fifo_rd_val  <= 1'b0;
        fif.fifo_rd_data <= DW'($urandom);
      end
    end
  end

  task automatic finish_frame();
    logic [DW-1:0] word;
    logic [8:0] exp;
    int unstable;
    unstable = 0;
    for (int b = 0; b < DW; b++) word[b] = samples[(b + 1) * CPB + CPB / 2];
    for (int k = 0; k < DW + 2; k++)
      for (int j = 0; j < CPB; j++)
        if (samples[k * CPB + j] !== samples[k * CPB]) unstable++;
    if (sent_q.size() > 0) exp = {1'b0, sent_q.pop_front()};
    else exp = 9'h1FF;
    check_val("bit_stable", unstable, 0);
    check_val("stop_bit", samples[(DW + 1) * CPB], 1);
    check_val("frame_done_pos", fd_bad, 0);
    check_val("frame_data", {1'b0, word}, exp);
    in_frame = 1'b0;
    last_end = cycle;
    frames++;
  endtask

  // Receiver model: samples tx once per cycle, away from the active edge.
  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      in_frame = 1'b0;
      sent_q.delete();
    end else begin
      if (fif.fifo_rd_en) begin
        check_val("rd_en_spacing", (cycle - last_pulse) >= 2, 1);
        rd_pulses++;
        last_pulse = cycle;
        pulse_q.push_back(cycle);
      end
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        pos = 0;
        fd_bad = 0;
        gap_q.push_back(cycle - last_end - 1);
        start_after_pulse = cycle - last_pulse;
      end
      if (in_frame) begin
        samples[pos] = tx;
        if (frame_done !== logic'(pos == FRAME - 1)) fd_bad++;
        pos++;
        if (pos == FRAME) finish_frame();
      end else if (frame_done) begin
        fd_stray++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (frames < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_val("frames_reached", frames >= n, 1);
  endtask

  int p0, f0, k, pushed;
  logic [DW-1:0] w;

  initial begin
    // 1: reset, idle with en low and an empty FIFO
    tick(3);
    @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_rd_en", fif.fifo_rd_en, 0);
    tick(1);
    reset = 1'b0;
    p0 = rd_pulses;
    tick(100);
    check_val("t1_no_rd_en", rd_pulses - p0, 0);
    check_val("t1_tx_idle", tx, 1);
    check_val("t1_busy", busy, 0);

    // 2: single word, en dropped while the request is in flight
    src_q.push_back(8'hA5);
    p0 = rd_pulses;
    f0 = frames;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_frames(f0 + 1, 200);
    check_val("t2_start_after_pulse", start_after_pulse, 2);
    tick(3);
    check_val("t2_one_pulse", rd_pulses - p0, 1);
    check_val("t2_busy_low", busy, 0);

    // 3: back-to-back frames, then the empty response
    gap_q.delete();
    src_q.push_back(8'h01);
    src_q.push_back(8'hFF);
    src_q.push_back(8'h80);
    p0 = rd_pulses;
    f0 = frames;
    en = 1'b1;
    wait_frames(f0 + 3, 500);
    tick(4);
    check_val("t3_gap_count", gap_q.size(), 3);
    check_val("t3_gap1", gap_q.size() >= 3 ? gap_q[1] : -1, 2);
    check_val("t3_gap2", gap_q.size() >= 3 ? gap_q[2] : -1, 2);
    check_val("t3_fourth_req", rd_pulses - p0 >= 4, 1);
    check_val("t3_tx_idle", tx, 1);
    en = 1'b0;
    tick(5);

    // 4: polling an empty FIFO, then a word arrives
    en = 1'b1;
    tick(2);
    pulse_q.delete();
    tick(12);
    check_val("t4_pulse_count", pulse_q.size() >= 4, 1);
    for (int i = 1; i < 4 && i < pulse_q.size(); i++)
      check_val("t4_poll_period", pulse_q[i] - pulse_q[i - 1], 3);
    f0 = frames;
    src_q.push_back(8'h3C);
    wait_frames(f0 + 1, 200);
    check_val("t4_start_after_pulse", start_after_pulse, 2);
    en = 1'b0;
    tick(6);

    // 5: en dropped in the middle of DATA
    src_q.push_back(8'h5A);
    p0 = rd_pulses;
    f0 = frames;
    en = 1'b1;
    for (k = 0; k < 200 && !(in_frame && pos >= 16); k++) @(negedge clk);
    check_val("t5_reach_data", in_frame && pos >= 16, 1);
    tick(1);
    en = 1'b0;
    for (k = 0; k < 200 && !frame_done; k++) @(negedge clk);
    check_val("t5_frame_done_seen", frame_done, 1);
    @(negedge clk);
    check_val("t5_busy_after_done", busy, 0);
    tick(20);
    check_val("t5_frames", frames - f0, 1);
    check_val("t5_no_more_rd_en", rd_pulses - p0, 1);

    // 6: reset during data bit 3, then a clean frame
    src_q.push_back(8'hC3);
    f0 = frames;
    en = 1'b1;
    for (k = 0; k < 200 && !(in_frame && pos >= 17); k++) @(negedge clk);
    check_val("t6_reach_bit3", in_frame && pos >= 17, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("t6_rst_tx", tx, 1);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_rd_en", fif.fifo_rd_en, 0);
    check_val("t6_no_frame", frames - f0, 0);
    src_q.push_back(8'h0F);
    tick(1);
    reset = 1'b0;
    wait_frames(f0 + 1, 200);
    en = 1'b0;
    tick(6);

    // 7: random words, random push timing and random en drops
    f0 = frames;
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      if (pushed < 25 && $urandom_range(0, 99) < 3) begin
        w = DW'($urandom);
        src_q.push_back(w);
        pushed++;
      end
      en = ($urandom_range(0, 9) != 0);
      tick(1);
    end
    en = 1'b1;
    for (k = 0; k < 5000 && frames < f0 + pushed; k++) @(negedge clk);
    check_val("t7_all_sent", frames - f0, pushed);
    en = 1'b0;
    tick(8);
    check_val("t7_fifo_drained", src_q.size(), 0);
    check_val("t7_no_lost_word", sent_q.size(), 0);
    check_val("stray_frame_done", fd_stray, 0);
    check_val("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
